// File: rtl/start_input_conditioner.sv
// start_input_conditioner
//   Front end for the processor's start/operand inputs. Both the raw Start
//   pushbutton and the raw operand switches are synchronised, then debounced.
//   Each debounced button press produces one single-cycle start pulse and
//   freezes the operand. No new start is accepted until the processor reports
//   Done and the button has been released.
//
// Parameters
//   WIDTH        operand width (number of switches)
//   SYNC_STAGES  synchroniser flops per raw input (>= 2)
//   DB_CYCLES    cycles an input must stay stable before it is accepted (>= 2)
//
// Ports
//   Clk        system clock, rising edge
//   Rst_n      asynchronous active-low reset
//   Btn_raw    raw Start pushbutton, active-high, bouncy, asynchronous
//   Sw_raw     raw operand switches, bouncy, asynchronous
//   Done       computation finished, from the processor FSM
//   Sw_stable  debounced live switch value, to the display mux
//   N_out      operand frozen when a start fires, to the datapath
//   Start_out  one-cycle start pulse, to the processor FSM
//   Busy       high while a computation is outstanding

module start_input_conditioner #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 500000
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Btn_raw,
   input  logic [WIDTH-1:0] Sw_raw,
   input  logic             Done,
   output logic [WIDTH-1:0] Sw_stable,
   output logic [WIDTH-1:0] N_out,
   output logic             Start_out,
   output logic             Busy
);

   localparam int                CNT_W    = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      FIRE,
      RUN,
      WAIT_REL
   } state_t;

   logic [SYNC_STAGES-1:0] btn_sync;
   logic [WIDTH-1:0]       sw_sync [SYNC_STAGES];
   logic                   s_btn;
   logic [WIDTH-1:0]       s_sw;
   logic [WIDTH-1:0]       s_sw_prev;

   logic [CNT_W-1:0]       cnt_b;
   logic [CNT_W-1:0]       cnt_s;
   logic                   btn_db;
   logic                   btn_db_d;
   logic                   btn_rise;

   state_t                 state;
   state_t                 next_state;
   logic                   load_n;

   assign s_btn    = btn_sync[SYNC_STAGES-1];
   assign s_sw     = sw_sync[SYNC_STAGES-1];
   assign btn_rise = btn_db & ~btn_db_d;

   // Synchroniser chains for the button and every switch bit.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         btn_sync <= '0;
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sw_sync[i] <= '0;
         end
      end else begin
         btn_sync   <= {btn_sync[SYNC_STAGES-2:0], Btn_raw};
         sw_sync[0] <= Sw_raw;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync[i] <= sw_sync[i-1];
         end
      end
   end

   // Button debounce: the accepted level only follows the synchronised input
   // after it has disagreed for DB_CYCLES consecutive cycles. Any agreement
   // mid-count throws the count away.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_b  <= '0;
         btn_db <= 1'b0;
      end else if (s_btn == btn_db) begin
         cnt_b <= '0;
      end else if (cnt_b == CNT_LAST) begin
         btn_db <= s_btn;
         cnt_b  <= '0;
      end else begin
         cnt_b <= cnt_b + CNT_ONE;
      end
   end

   // Switch debounce with one counter for the whole vector. The previous
   // synchronised value is kept so that a new pattern arriving while a count
   // is already running restarts the count; the first differing cycle just
   // starts counting.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_s     <= '0;
         s_sw_prev <= '0;
         Sw_stable <= '0;
      end else begin
         s_sw_prev <= s_sw;
         if (s_sw == Sw_stable) begin
            cnt_s <= '0;
         end else if ((s_sw != s_sw_prev) && (cnt_s != '0)) begin
            cnt_s <= '0;
         end else if (cnt_s == CNT_LAST) begin
            Sw_stable <= s_sw;
            cnt_s     <= '0;
         end else begin
            cnt_s <= cnt_s + CNT_ONE;
         end
      end
   end

   // Delayed copy of the debounced button for rising-edge detection.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         btn_db_d <= 1'b0;
      end else begin
         btn_db_d <= btn_db;
      end
   end

   // State register and the operand latch, loaded only on IDLE -> FIRE.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
         N_out <= '0;
      end else begin
         state <= next_state;
         if (load_n) begin
            N_out <= Sw_stable;
         end
      end
   end

   // Next state and Moore outputs. Done takes priority over a fresh press in
   // RUN, and WAIT_REL keeps a button still held from the last run from
   // starting another one.
   always_comb begin
      next_state = state;
      Start_out  = 1'b0;
      Busy       = 1'b0;
      load_n     = 1'b0;
      case (state)
         IDLE: begin
            if (btn_rise) begin
               next_state = FIRE;
               load_n     = 1'b1;
            end
         end
         FIRE: begin
            Start_out  = 1'b1;
            Busy       = 1'b1;
            next_state = RUN;
         end
         RUN: begin
            Busy = 1'b1;
            if (Done) begin
               next_state = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!btn_db) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_start_input_conditioner.sv
// tb_start_input_conditioner
//   Self-checking bench for start_input_conditioner with DB_CYCLES=4,
//   SYNC_STAGES=2, WIDTH=8. The switch debounce is driven from a table of
//   {switch value, hold cycles, expected Sw_stable} records. Button presses push
//   the expected start cycle and operand into a queue, and a monitor pops an
//   entry whenever Start_out fires. Hand-written sequences cover the
//   multi-cycle corner cases.

module tb_start_input_conditioner;

   localparam int WIDTH       = 8;
   localparam int SYNC_STAGES = 2;
   localparam int DB_CYCLES   = 4;
   localparam int START_LAT   = SYNC_STAGES + DB_CYCLES + 1;

   typedef struct {
      int         due;
      logic [7:0] n;
   } start_exp_t;

   typedef struct {
      logic [7:0] sw;
      int         hold;
      logic [7:0] exp_stable;
   } sw_vec_t;

   logic             Clk = 1'b0;
   logic             Rst_n;
   logic             Btn_raw;
   logic [WIDTH-1:0] Sw_raw;
   logic             Done;
   logic [WIDTH-1:0] Sw_stable;
   logic [WIDTH-1:0] N_out;
   logic             Start_out;
   logic             Busy;

   int         cyc = 0;
   int         compared = 0;
   int         mismatched = 0;
   start_exp_t start_q[$];
   start_exp_t mon_exp;
   sw_vec_t    sw_vecs[11];

   start_input_conditioner #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Btn_raw  (Btn_raw),
      .Sw_raw   (Sw_raw),
      .Done     (Done),
      .Sw_stable(Sw_stable),
      .N_out    (N_out),
      .Start_out(Start_out),
      .Busy     (Busy)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   // Drives the button and, for a press that should fire, queues the start.
   task automatic apply_stimulus(input logic btn, input logic expect_start, input logic [7:0] exp_n);
      start_exp_t e;
      Btn_raw = btn;
      if (expect_start) begin
         e.due = cyc + START_LAT;
         e.n   = exp_n;
         start_q.push_back(e);
      end
   endtask

   // Every Start_out pulse must match the head of the queue in cycle and
   // operand; a head entry whose cycle has passed is a missing start.
   always @(posedge Clk) begin
      #1;
      if (Start_out === 1'b1) begin
         if (start_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_start: Start_out=1 at cycle %0d, expected 0", cyc);
         end else begin
            mon_exp = start_q.pop_front();
            check_output("start_cycle", cyc, mon_exp.due);
            check_output("start_n_out", {24'd0, N_out}, {24'd0, mon_exp.n});
         end
      end else if (start_q.size() != 0 && cyc > start_q[0].due) begin
         mon_exp = start_q.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL missing_start: no Start_out by cycle %0d, expected at cycle %0d", cyc, mon_exp.due);
      end
   end

   initial begin
      sw_vecs[0]  = '{8'hFF, 3, 8'h00};
      sw_vecs[1]  = '{8'h00, 8, 8'h00};
      sw_vecs[2]  = '{8'hA5, 5, 8'h00};
      sw_vecs[3]  = '{8'hA5, 1, 8'hA5};
      sw_vecs[4]  = '{8'h3C, 6, 8'h3C};
      sw_vecs[5]  = '{8'hC3, 2, 8'h3C};
      sw_vecs[6]  = '{8'h3C, 8, 8'h3C};
      sw_vecs[7]  = '{8'h11, 2, 8'h3C};
      sw_vecs[8]  = '{8'h22, 6, 8'h3C};
      sw_vecs[9]  = '{8'h22, 1, 8'h22};
      sw_vecs[10] = '{8'h2F, 6, 8'h2F};

      Rst_n   = 1'b0;
      Btn_raw = 1'b0;
      Sw_raw  = '0;
      Done    = 1'b0;

      // Reset state
      step(3);
      check_output("rst_sw_stable", {24'd0, Sw_stable}, 32'h0);
      check_output("rst_n_out", {24'd0, N_out}, 32'h0);
      check_output("rst_start", {31'd0, Start_out}, 32'h0);
      check_output("rst_busy", {31'd0, Busy}, 32'h0);
      Rst_n = 1'b1;
      step(3);

      // Switch debounce table: glitches, short pulses and mid-count changes
      for (int i = 0; i < 11; i++) begin
         Sw_raw = sw_vecs[i].sw;
         step(sw_vecs[i].hold);
         check_output($sformatf("sw_vec%0d", i), {24'd0, Sw_stable}, {24'd0, sw_vecs[i].exp_stable});
      end
      check_output("sw_busy_idle", {31'd0, Busy}, 32'h0);

      // Clean press held 40 cycles with operand 2F
      apply_stimulus(1'b1, 1'b1, 8'h2F);
      step(40);
      check_output("run_busy", {31'd0, Busy}, 32'h1);
      check_output("run_n_out", {24'd0, N_out}, 32'h2F);

      // New switches and a re-press during RUN
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(10);
      Sw_raw = 8'h55;
      apply_stimulus(1'b1, 1'b0, 8'h00);
      step(6);
      check_output("run_sw_stable", {24'd0, Sw_stable}, 32'h55);
      step(6);
      check_output("run_n_frozen", {24'd0, N_out}, 32'h2F);
      check_output("run_busy_repress", {31'd0, Busy}, 32'h1);

      // Done while the button is still held
      Done = 1'b1;
      step(1);
      Done = 1'b0;
      check_output("done_busy", {31'd0, Busy}, 32'h0);
      step(15);
      check_output("held_busy", {31'd0, Busy}, 32'h0);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(12);

      // Bouncing press latches the current Sw_stable
      apply_stimulus(1'b1, 1'b0, 8'h00);
      step(2);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(2);
      apply_stimulus(1'b1, 1'b0, 8'h00);
      step(2);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(2);
      apply_stimulus(1'b1, 1'b1, 8'h55);
      step(12);
      check_output("bounce_busy", {31'd0, Busy}, 32'h1);
      check_output("bounce_n_out", {24'd0, N_out}, 32'h55);

      // Done in the same cycle as a debounced rising edge in RUN
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(10);
      apply_stimulus(1'b1, 1'b0, 8'h00);
      step(DB_CYCLES + SYNC_STAGES);
      Done = 1'b1;
      step(1);
      Done = 1'b0;
      check_output("simul_busy", {31'd0, Busy}, 32'h0);
      step(10);
      check_output("simul_wait_busy", {31'd0, Busy}, 32'h0);
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(12);

      // Done in IDLE is ignored
      Done = 1'b1;
      step(1);
      Done = 1'b0;
      check_output("idle_done_busy", {31'd0, Busy}, 32'h0);
      step(2);

      // Reset in RUN with the button held through reset
      apply_stimulus(1'b1, 1'b1, 8'h55);
      step(12);
      check_output("pre_rst_busy", {31'd0, Busy}, 32'h1);
      #2;
      Rst_n = 1'b0;
      #1;
      check_output("async_rst_busy", {31'd0, Busy}, 32'h0);
      check_output("async_rst_start", {31'd0, Start_out}, 32'h0);
      check_output("async_rst_n_out", {24'd0, N_out}, 32'h0);
      check_output("async_rst_sw", {24'd0, Sw_stable}, 32'h0);
      @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      apply_stimulus(1'b1, 1'b1, 8'h55);
      step(12);
      check_output("post_rst_busy", {31'd0, Busy}, 32'h1);
      check_output("post_rst_n_out", {24'd0, N_out}, 32'h55);

      // Wind down and make sure every expected start was seen
      Done = 1'b1;
      step(1);
      Done = 1'b0;
      apply_stimulus(1'b0, 1'b0, 8'h00);
      step(12);
      check_output("final_busy", {31'd0, Busy}, 32'h0);
      check_output("pending_starts", start_q.size(), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
